// File: rtl/dispatch_queue.sv
// dispatch_queue: W-wide in-order buffer between fetch and dispatch.
// Lane packet layout is {valid, pc, inst}; squash flushes, a dispatched WFI freezes the queue.
module dispatch_queue #(
    parameter int          W     = 3,
    parameter int          DEPTH = 8,
    parameter int          CW    = $clog2(DEPTH + 1),
    parameter int          AW    = $clog2(W + 1),
    parameter int          PCW   = 32,
    parameter int          PW    = 1 + PCW + 32,
    parameter logic [31:0] WFI   = 32'h10500073
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            squash,
    input  logic [W*PW-1:0] if_packet_in,
    output logic [AW-1:0]   accept_num,
    output logic [CW-1:0]   free_slots,
    output logic [W*PW-1:0] disp_packet,
    output logic [W-1:0]    disp_valid,
    input  logic [W-1:0]    d_stall,
    output logic [AW-1:0]   disp_num,
    output logic            halted,
    output logic            empty,
    output logic            full
);
    localparam int PTRW = $clog2(DEPTH);
    logic [PW-1:0]   mem [DEPTH];
    logic [PTRW-1:0] head, tail;
    logic [CW-1:0]   count, in_cnt;
    logic [PW-1:0]   pkt;
    logic            in_run, out_run, lane_ok, wfi_seen, wfi_go;
    assign free_slots = CW'(DEPTH) - count;
    assign empty      = count == '0;
    assign full       = count == CW'(DEPTH);
    always_comb begin
        in_cnt = '0;
        in_run = 1'b1;
        for (int k = 0; k < W; k++) begin
            in_run = in_run & if_packet_in[k*PW+PW-1];
            in_cnt = in_cnt + CW'(in_run);
        end
        accept_num = (halted | squash) ? '0 : AW'((in_cnt < free_slots) ? in_cnt : free_slots);
    end
    // A dispatched WFI blocks all younger lanes in the same cycle.
    always_comb begin
        disp_packet = '0;
        disp_valid  = '0;
        disp_num    = '0;
        pkt         = '0;
        lane_ok     = 1'b0;
        out_run     = ~squash;
        wfi_seen    = 1'b0;
        wfi_go      = 1'b0;
        for (int k = 0; k < W; k++) begin
            lane_ok                   = (CW'(k) < count) & ~halted;
            pkt                       = lane_ok ? mem[head + PTRW'(k)] : '0;
            disp_valid[k]             = lane_ok;
            disp_packet[k*PW +: PW]   = pkt;
            out_run                   = out_run & lane_ok & ~d_stall[k] & ~wfi_seen;
            wfi_seen                  = pkt[31:0] == WFI;
            wfi_go                    = wfi_go | (out_run & wfi_seen);
            disp_num                  = disp_num + AW'(out_run);
        end
    end
    always_ff @(posedge clock) begin
        for (int k = 0; k < W; k++)
            if (AW'(k) < accept_num) mem[tail + PTRW'(k)] <= if_packet_in[k*PW +: PW];
    end
    always_ff @(posedge clock) begin
        if (reset | squash) begin
            head   <= '0;
            tail   <= '0;
            count  <= '0;
            halted <= 1'b0;
        end else begin
            head   <= head + PTRW'(disp_num);
            tail   <= tail + PTRW'(accept_num);
            count  <= count + CW'(accept_num) - CW'(disp_num);
            halted <= halted | wfi_go;
        end
    end
endmodule

// File: tb/tb_dispatch_queue.sv
// tb_dispatch_queue: directed table plus randomized traffic against a queue-based model.
module tb_dispatch_queue;
    localparam int          W     = 3;
    localparam int          DEPTH = 8;
    localparam int          PW    = 65;
    localparam logic [31:0] WFI   = 32'h10500073;
    localparam logic [31:0] NOP   = 32'h00000013;
    logic            clock = 1'b0;
    logic            reset, squash;
    logic [W*PW-1:0] if_packet_in, disp_packet;
    logic [1:0]      accept_num, disp_num;
    logic [3:0]      free_slots;
    logic [W-1:0]    disp_valid, d_stall;
    logic            halted, empty, full;
    always #5 clock = ~clock;
    dispatch_queue #(.W(W), .DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset), .squash(squash), .if_packet_in(if_packet_in),
        .accept_num(accept_num), .free_slots(free_slots), .disp_packet(disp_packet),
        .disp_valid(disp_valid), .d_stall(d_stall), .disp_num(disp_num),
        .halted(halted), .empty(empty), .full(full)
    );
    typedef struct { logic [31:0] pc; logic [31:0] inst; } ent_t;
    typedef struct {
        bit r; bit s; logic [2:0] v; int w; logic [2:0] st;
        int acc; int disp; logic [2:0] dv; int pc0; int free; bit h;
    } row_t;
    ent_t     q[$];
    row_t     tbl[$];
    bit       m_halt;
    int       npc, e_acc, e_disp, tests, fails;
    logic [2:0] vm;
    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic drive(bit r, bit s, logic [2:0] v, int w, logic [2:0] st);
        reset   = r;
        squash  = s;
        d_stall = st;
        vm      = v;
        for (int k = 0; k < W; k++)
            if_packet_in[k*PW +: PW] = {v[k], 32'(npc + 4*k), (k == w) ? WFI : NOP};
    endtask
    // Expected behaviour derived from queue contents and the dispatch rules.
    task automatic check_model();
        int run, room;
        logic [2:0] dv;
        run = 0;
        while (run < W && vm[run]) run++;
        room  = DEPTH - q.size();
        e_acc = (m_halt || squash) ? 0 : (run < room ? run : room);
        e_disp = 0;
        if (!m_halt && !squash)
            for (int k = 0; k < W && k < q.size(); k++) begin
                if (d_stall[k]) break;
                e_disp++;
                if (q[k].inst == WFI) break;
            end
        dv = '0;
        if (!m_halt)
            for (int k = 0; k < W && k < q.size(); k++) dv[k] = 1'b1;
        chk("accept_num", accept_num, e_acc);
        chk("disp_num", disp_num, e_disp);
        chk("disp_valid", disp_valid, dv);
        chk("free_slots", free_slots, room);
        chk("empty", empty, q.size() == 0);
        chk("full", full, q.size() == DEPTH);
        chk("halted", halted, m_halt);
        chk("count_range", free_slots <= DEPTH, 1);
        for (int k = 0; k < W; k++) begin
            chk("lane_valid", disp_packet[k*PW+PW-1], dv[k]);
            if (dv[k]) begin
                chk("lane_pc", disp_packet[k*PW+32 +: 32], q[k].pc);
                chk("lane_inst", disp_packet[k*PW +: 32], q[k].inst);
            end
        end
    endtask
    task automatic update();
        if (reset || squash) begin
            q.delete();
            m_halt = 1'b0;
        end else begin
            for (int i = 0; i < e_disp; i++) begin
                if (q[0].inst == WFI) m_halt = 1'b1;
                void'(q.pop_front());
            end
            for (int k = 0; k < e_acc; k++)
                q.push_back('{pc: if_packet_in[k*PW+32 +: 32], inst: if_packet_in[k*PW +: 32]});
            npc += 4 * e_acc;
        end
    endtask
    initial begin
        tests  = 0;
        fails  = 0;
        npc    = 0;
        m_halt = 1'b0;
        drive(1, 0, 3'b000, 3, 3'b000);
        @(posedge clock);
        //               r s  v      w  st     acc disp dv     pc0 free h
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 3, 0, 3'b000,   0, 8, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b000, 0, 3, 3'b111,   0, 5, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 3, 0, 3'b000,   0, 8, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b010, 0, 1, 3'b111,  12, 5, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b110, 0, 1, 3'b011,  16, 6, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b111, 3, 0, 3'b001,  20, 7, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b111, 3, 0, 3'b111,  20, 4, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b111, 1, 0, 3'b111,  20, 1, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b111, 0, 0, 3'b111,  20, 0, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 0, 3, 3'b111,  20, 0, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 3, 3, 3'b111,  32, 3, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 3, 3, 3'b111,  44, 3, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b000, 0, 3, 3'b111,  56, 3, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b000, 0, 2, 3'b011,  68, 6, 0});
        tbl.push_back('{0, 0, 3'b101, 3, 3'b000, 1, 0, 3'b000,   0, 8, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b111, 0, 0, 3'b001,  76, 7, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b000, 0, 1, 3'b001,  76, 7, 0});
        tbl.push_back('{0, 0, 3'b111, 1, 3'b111, 3, 0, 3'b000,   0, 8, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b000, 0, 2, 3'b111,  80, 5, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 0, 0, 3'b000,   0, 7, 1});
        tbl.push_back('{0, 0, 3'b001, 3, 3'b000, 0, 0, 3'b000,   0, 7, 1});
        tbl.push_back('{0, 1, 3'b111, 3, 3'b000, 0, 0, 3'b000,   0, 7, 1});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b111, 3, 0, 3'b000,   0, 8, 0});
        tbl.push_back('{0, 0, 3'b011, 3, 3'b111, 2, 0, 3'b111,  92, 5, 0});
        tbl.push_back('{0, 1, 3'b111, 3, 3'b000, 0, 0, 3'b111,  92, 3, 0});
        tbl.push_back('{0, 0, 3'b111, 3, 3'b000, 3, 0, 3'b000,   0, 8, 0});
        tbl.push_back('{0, 0, 3'b011, 3, 3'b111, 2, 0, 3'b111, 112, 5, 0});
        tbl.push_back('{1, 1, 3'b111, 3, 3'b000, 0, 0, 3'b111, 112, 3, 0});
        tbl.push_back('{0, 0, 3'b000, 3, 3'b000, 0, 0, 3'b000,   0, 8, 0});
        foreach (tbl[i]) begin
            @(negedge clock);
            drive(tbl[i].r, tbl[i].s, tbl[i].v, tbl[i].w, tbl[i].st);
            #1;
            check_model();
            chk($sformatf("row%0d_acc", i), accept_num, tbl[i].acc);
            chk($sformatf("row%0d_disp", i), disp_num, tbl[i].disp);
            chk($sformatf("row%0d_dv", i), disp_valid, tbl[i].dv);
            chk($sformatf("row%0d_free", i), free_slots, tbl[i].free);
            chk($sformatf("row%0d_empty", i), empty, tbl[i].free == DEPTH);
            chk($sformatf("row%0d_full", i), full, tbl[i].free == 0);
            chk($sformatf("row%0d_halt", i), halted, tbl[i].h);
            if (tbl[i].dv[0]) chk($sformatf("row%0d_pc0", i), disp_packet[32 +: 32], tbl[i].pc0);
            @(posedge clock);
            update();
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            drive($urandom_range(0, 59) == 0, $urandom_range(0, 19) == 0,
                  ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111,
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 2)) : 3,
                  ($urandom_range(0, 1) == 0) ? 3'($urandom) : 3'b000);
            #1;
            check_model();
            @(posedge clock);
            update();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/dispatch_queue.md
Name: dispatch_queue

Overview:
- Parametrised, W-wide in-order instruction buffer between fetch (IF) and dispatch (decode/rename).
- Decouples fetch from dispatch structural stalls (RS, ROB, free list).
- Enforces in-order dispatch: a stalled lane blocks every younger lane.
- Supports squash flush and halt (WFI) freeze.

Parameters:
- W, 3: fetch/dispatch width in instructions per cycle.
- DEPTH, 8: buffer entries; power of two, DEPTH >= W.
- CW, $clog2(DEPTH+1): width of count/free fields.

Ports:
- clock  in  1  system clock, all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- squash  in  1  branch-mispredict flush; synchronous.
- if_packet_in  in  W x IF_ID_PACKET  fetched instructions; lane 0 oldest; .valid per lane.
- accept_num  out  $clog2(W+1)  number of input lanes accepted this cycle (combinational).
- free_slots  out  CW  DEPTH - count, registered-state based.
- disp_packet  out  W x IF_ID_PACKET  oldest W buffered instructions; lane 0 = head.
- disp_valid  out  W  per-lane presentation valid; always a contiguous prefix.
- d_stall  in  W  per-lane structural stall from dispatch (rs | rob | ~free_reg).
- disp_num  out  $clog2(W+1)  number of lanes dispatched this cycle (combinational).
- halted  out  1  WFI has been dispatched; queue frozen.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.

Behaviour:
- State:
  - Storage: DEPTH x IF_ID_PACKET.
  - Pointers: head, tail, each $clog2(DEPTH) bits, wrap modulo DEPTH.
  - Registers: count (CW bits), halted.
- Reset (reset=1 at posedge):
  - head = tail = count = 0; halted = 0.
  - Outputs after reset: disp_valid = 0, empty = 1, full = 0, free_slots = DEPTH, accept_num = 0, disp_num = 0.
- Input acceptance:
  - in_cnt = length of the leading run of valid lanes in if_packet_in; lanes after the first invalid lane are ignored.
  - accept_num = (halted | squash) ? 0 : min(in_cnt, free_slots).
  - Accepted lanes k < accept_num are written to entry (tail + k) mod DEPTH; tail += accept_num.
  - Fetch must re-present unaccepted lanes; the queue never partially stores a lane.
- Presentation:
  - disp_valid[k] = (k < count) & ~halted.
  - disp_packet[k] = entry (head + k) mod DEPTH; when disp_valid[k] = 0 the packet is driven with .valid = 0.
  - No same-cycle bypass: minimum latency from accept to presentation is 1 cycle.
- Dispatch:
  - disp_num = number of leading lanes with disp_valid[k] & ~d_stall[k]; the first stalled lane blocks all younger lanes.
  - WFI truncation: if the instruction at lane j with j < disp_num equals `WFI, disp_num is truncated to j+1.
  - head += disp_num.
- Halt: when a WFI is dispatched (it sits at lane disp_num-1), halted is set next cycle. Halted holds until reset or squash.
- Count update: count_next = count + accept_num - disp_num. Simultaneous enqueue and dequeue is legal; free_slots reflects registered count only, so slots freed this cycle are usable next cycle.
- Squash:
  - Next state: head = tail = count = 0, halted = 0.
  - Same cycle: accept_num = 0 and disp_num = 0, i.e. no dispatch and no accept.
  - Squash has priority over all other updates.
- Reset and squash in the same cycle: reset wins; identical end state.
- Wrap-around: pointer increments are modulo DEPTH; any packet run straddling entry DEPTH-1 -> 0 must preserve order.
- Full: accept_num = 0, fetch holds. Empty: disp_valid = 0, disp_num = 0.
- Invariant: 0 <= count <= DEPTH at all times; the bench asserts it every cycle.

Test Plan (W=3, DEPTH=8):
- Reset, then fetch 3 valid lanes (PC 0,4,8) with d_stall = 000.
  - Cycle 0: accept_num = 3.
  - Next cycle: disp_valid = 111, lane 0 PC = 0, disp_num = 3.
  - Following cycle: empty = 1.
- In-order stall: buffer holds PC 0,4,8; d_stall = 010.
  - disp_num = 1 and only PC 0 leaves.
  - Next cycle: lane 0 PC = 4, count = 2.
- Fill and wrap, d_stall = 111:
  - Fetch 3,3,3: accept_num = 3,3,2; full = 1, free_slots = 0.
  - Release stalls over 3 cycles while fetching: output order is PC-monotonic across entry 7 -> 0.
- Input valid = 101: accept_num = 1, only lane 0 stored.
- WFI at lane 1 with d_stall = 000 and 3 entries: disp_num = 2, then halted = 1, disp_valid = 000, accept_num = 0 for all inputs.
- Squash with count = 5 while fetching 3 and d_stall = 000:
  - Same cycle: disp_num = 0, accept_num = 0.
  - Next cycle: empty = 1, free_slots = 8, halted = 0.
  - Repeat with reset asserted simultaneously: same result.
